// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: sequential shift-and-add-3 binary-to-BCD converter with saturating overflow
module bcd_convert_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t          state, state_nxt;
  logic [BIN_W-1:0] sr;
  logic [BW-1:0]   work, adj, work_nxt, sat;
  logic [CW-1:0]   cnt;
  logic            ovf_s, shout, accept, last;
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign adj[4*k+:4] = work[4*k+:4] >= 4'd5 ? work[4*k+:4] + 4'd3 : work[4*k+:4];
    assign sat[4*k+:4] = 4'd9;
  end
  // bit leaving the top digit means the value no longer fits in DIGITS digits
  assign shout    = adj[BW-1];
  assign work_nxt = {adj[BW-2:0], sr[BIN_W-1]};
  always_comb begin
    accept    = start && state != CONV;
    last      = state == CONV && cnt == CW'(1);
    busy      = state == CONV;
    done      = state == DONE;
    state_nxt = accept ? CONV : last ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sr       <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_s    <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sr    <= bin;
        work  <= '0;
        ovf_s <= 1'b0;
        cnt   <= CW'(BIN_W);
      end else if (busy) begin
        sr    <= sr << 1;
        work  <= work_nxt;
        ovf_s <= ovf_s | shout;
        cnt   <= cnt - 1'b1;
      end
      if (last) begin
        overflow <= ovf_s | shout;
        bcd      <= (ovf_s | shout) ? sat : work_nxt;
      end
    end
  end
endmodule

// File: tb/tb_bcd_convert_seq.sv
// tb_bcd_convert_seq: random and directed checks of three converter configurations against a decimal model
module tb_bcd_convert_seq;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [3:0]  bcd_c;
  int          n_chk = 0, n_fail = 0;
  int          rem [3];
  longint      cap [3], e_bcd [3];
  bit          e_ovf [3], e_done [3];

  bcd_convert_seq #(.BIN_W(8), .DIGITS(3)) dut_a (.clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a));
  bcd_convert_seq #(.BIN_W(7), .DIGITS(2)) dut_b (.clk(clk), .reset(reset), .start(start), .bin(bin[6:0]),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b));
  bcd_convert_seq #(.BIN_W(1), .DIGITS(1)) dut_c (.clk(clk), .reset(reset), .start(start), .bin(bin[0:0]),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c));

  always #5 clk = ~clk;

  function automatic int width_of(input int i);
    return i == 0 ? 8 : i == 1 ? 7 : 1;
  endfunction
  function automatic int digits_of(input int i);
    return i == 0 ? 3 : i == 1 ? 2 : 1;
  endfunction
  function automatic longint lim(input int d);
    longint l = 1;
    for (int k = 0; k < d; k++) l *= 10;
    return l;
  endfunction
  function automatic longint dec(input longint x, input int d);
    longint r = 0;
    bit     o = x >= lim(d);
    for (int k = 0; k < d; k++) begin
      r |= (o ? 64'd9 : x % 10) << (4 * k);
      x /= 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: a conversion is a countdown of BIN_W cycles, then the decimal value of the captured input
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        rem[i] = 0; e_done[i] = 0; e_bcd[i] = 0; e_ovf[i] = 0;
      end else begin
        e_done[i] = 0;
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) begin
            e_done[i] = 1;
            e_ovf[i]  = cap[i] >= lim(digits_of(i));
            e_bcd[i]  = dec(cap[i], digits_of(i));
          end
        end else if (start) begin
          rem[i] = width_of(i);
          cap[i] = longint'(bin) & ((64'd1 << width_of(i)) - 1);
        end
      end
    end
    #1;
    chk("busy_a", busy_a, rem[0] > 0);  chk("done_a", done_a, e_done[0]);
    chk("bcd_a", bcd_a, e_bcd[0]);      chk("ovf_a", ovf_a, e_ovf[0]);
    chk("busy_b", busy_b, rem[1] > 0);  chk("done_b", done_b, e_done[1]);
    chk("bcd_b", bcd_b, e_bcd[1]);      chk("ovf_b", ovf_b, e_ovf[1]);
    chk("busy_c", busy_c, rem[2] > 0);  chk("done_c", done_c, e_done[2]);
    chk("bcd_c", bcd_c, e_bcd[2]);      chk("ovf_c", ovf_c, e_ovf[2]);
  end

  // called just after a rising edge; lat counts cycles from the accepting edge to done
  task automatic convert(input logic [7:0] v, output int lat);
    start = 1'b1;
    bin   = v;
    lat   = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end while (!done_a && lat < 40);
  endtask

  initial begin
    int lat, n;
    int order [256];
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0);
    chk("rst_bcd", bcd_a, 0);   chk("rst_ovf", ovf_a, 0);
    @(negedge clk) reset = 1'b1;
    convert(8'd0, lat);
    chk("lat0", lat, 9); chk("bcd0", bcd_a, 12'h000); chk("ovf0", ovf_a, 0);
    convert(8'd255, lat);
    chk("bcd255", bcd_a, 12'h255); chk("ovf255", ovf_a, 0);
    convert(8'd100, lat);
    chk("bcd100", bcd_a, 12'h100);
    convert(8'd99, lat);
    chk("bcd99_b", bcd_b, 8'h99); chk("ovf99_b", ovf_b, 0);
    convert(8'd127, lat);
    chk("bcd127_b", bcd_b, 8'h99); chk("ovf127_b", ovf_b, 1);
    chk("bcd127_a", bcd_a, 12'h127); chk("bcd127_c", bcd_c, 4'h1);
    // starts during a conversion are ignored
    start = 1'b1; bin = 8'd10;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bin = 8'($urandom);
      @(posedge clk); #1;
      chk("busy_hold", busy_a, 1);
    end
    start = 1'b0;
    n = 0;
    repeat (12) begin @(posedge clk); #1; n += int'(done_a); end
    chk("single_done", n, 1); chk("bcd10", bcd_a, 12'h010);
    // reset mid-conversion
    start = 1'b1; bin = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
    #1;
    chk("mid_busy", busy_a, 0); chk("mid_done", done_a, 0);
    chk("mid_bcd", bcd_a, 0);   chk("mid_ovf", ovf_a, 0);
    @(negedge clk) reset = 1'b1;
    n = 0;
    repeat (15) begin @(posedge clk); #1; n += int'(done_a); end
    chk("no_done_after_rst", n, 0);
    convert(8'd173, lat);
    chk("bcd173", bcd_a, 12'h173);
    // start held continuously: back-to-back conversions
    start = 1'b1; bin = 8'd42;
    @(posedge clk); #1;
    bin = 8'd37;
    n = 1;
    while (!done_a && n < 40) begin @(posedge clk); #1; n++; end
    chk("held_lat", n, 9); chk("held_bcd42", bcd_a, 12'h042);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done_a && n < 40);
    start = 1'b0;
    chk("held_period", n, 9); chk("held_bcd37", bcd_a, 12'h037);
    // every 8-bit value once, in random order with random gaps
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      convert(8'(order[i]), lat);
      chk("sweep_lat", lat, 9);
      chk("sweep_bcd", bcd_a, dec(longint'(order[i]), 3));
    end
    // free-running random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = $urandom_range(0, 3) == 0;
      bin   = 8'($urandom);
      reset = $urandom_range(0, 299) != 0;
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
